// File: rtl/gpr_wb_arbiter_if.sv
// Write-back arbiter bus: two producer handshakes, the issue/decode
// scoreboard ports, and the registered register-file write port.
interface gpr_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // ALU write-back producer
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_dest;
    logic [XLEN-1:0] alu_data;
    // LSU load-return producer
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_dest;
    logic [XLEN-1:0] lsu_data;
    // Issue and decode hazard check
    logic            iss_en;
    logic [AW-1:0]   iss_dest;
    logic [AW-1:0]   chk_addr_1;
    logic [AW-1:0]   chk_addr_2;
    logic            chk_busy_1;
    logic            chk_busy_2;
    // Register-file write port
    logic            reg_write_en;
    logic [AW-1:0]   reg_write_dest;
    logic [XLEN-1:0] reg_write_data;

    // Producer / pipeline side: drives requests, sees grants and write port
    modport master (
        output alu_valid, alu_dest, alu_data,
        output lsu_valid, lsu_dest, lsu_data,
        output iss_en, iss_dest, chk_addr_1, chk_addr_2,
        input  alu_ready, lsu_ready, chk_busy_1, chk_busy_2,
        input  reg_write_en, reg_write_dest, reg_write_data
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  lsu_valid, lsu_dest, lsu_data,
        input  iss_en, iss_dest, chk_addr_1, chk_addr_2,
        output alu_ready, lsu_ready, chk_busy_1, chk_busy_2,
        output reg_write_en, reg_write_dest, reg_write_data
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: grants the ALU or LSU one write per cycle with
// alternating priority on conflict, drives a registered write port, and
// keeps a pending-write scoreboard for decode RAW hazard detection.
module gpr_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    gpr_wb_arbiter_if.slave    bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic [0:0] {
        GNT_ALU = 1'b0,
        GNT_LSU = 1'b1
    } grant_e;

    grant_e            r_last_grant;
    logic [NREG-1:0]   r_pending;
    logic              r_reg_write_en;
    logic [AW-1:0]     r_reg_write_dest;
    logic [XLEN-1:0]   r_reg_write_data;

    logic              w_alu_grant;
    logic              w_lsu_grant;
    logic              w_xfer;
    logic [AW-1:0]     w_xfer_dest;
    logic [XLEN-1:0]   w_xfer_data;
    logic [NREG-1:0]   w_pending_nxt;
    logic              w_busy_1;
    logic              w_busy_2;

    // Pick one requester; on a conflict the one that did not win last time
    always_comb begin
        w_alu_grant = 1'b0;
        w_lsu_grant = 1'b0;
        case ({bus.alu_valid, bus.lsu_valid})
            2'b10: w_alu_grant = 1'b1;
            2'b01: w_lsu_grant = 1'b1;
            2'b11: begin
                if (r_last_grant == GNT_ALU) begin
                    w_lsu_grant = 1'b1;
                end else begin
                    w_alu_grant = 1'b1;
                end
            end
            default: begin
                w_alu_grant = 1'b0;
                w_lsu_grant = 1'b0;
            end
        endcase
    end

    // Granted handshake implies a transfer; mux the winner's payload
    always_comb begin
        w_xfer = w_alu_grant | w_lsu_grant;
        if (w_lsu_grant) begin
            w_xfer_dest = bus.lsu_dest;
            w_xfer_data = bus.lsu_data;
        end else begin
            w_xfer_dest = bus.alu_dest;
            w_xfer_data = bus.alu_data;
        end
    end

    // Remember the last winner; it only moves when something transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_ALU;
        end else if (w_xfer) begin
            r_last_grant <= w_lsu_grant ? GNT_LSU : GNT_ALU;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Registered write port; x0 writes are accepted but never enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write_en   <= 1'b0;
            r_reg_write_dest <= {AW{1'b0}};
            r_reg_write_data <= {XLEN{1'b0}};
        end else if (w_xfer) begin
            r_reg_write_en   <= (w_xfer_dest != {AW{1'b0}});
            r_reg_write_dest <= w_xfer_dest;
            r_reg_write_data <= w_xfer_data;
        end else begin
            r_reg_write_en   <= 1'b0;
        end
    end

    // Scoreboard next state: clear on write-back, then set on issue so a
    // newer producer of the same register keeps it pending
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_xfer) begin
            w_pending_nxt[w_xfer_dest] = 1'b0;
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        if (bus.iss_en && (bus.iss_dest != {AW{1'b0}})) begin
            w_pending_nxt[bus.iss_dest] = 1'b1;
        end else begin
            w_pending_nxt = w_pending_nxt;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= {NREG{1'b0}};
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Busy also covers the cycle the register file write is in flight
    always_comb begin
        w_busy_1 = (bus.chk_addr_1 != {AW{1'b0}}) &&
                   (r_pending[bus.chk_addr_1] ||
                    (r_reg_write_en && (r_reg_write_dest == bus.chk_addr_1)));
        w_busy_2 = (bus.chk_addr_2 != {AW{1'b0}}) &&
                   (r_pending[bus.chk_addr_2] ||
                    (r_reg_write_en && (r_reg_write_dest == bus.chk_addr_2)));
    end

    assign bus.alu_ready      = w_alu_grant;
    assign bus.lsu_ready      = w_lsu_grant;
    assign bus.chk_busy_1     = w_busy_1;
    assign bus.chk_busy_2     = w_busy_2;
    assign bus.reg_write_en   = r_reg_write_en;
    assign bus.reg_write_dest = r_reg_write_dest;
    assign bus.reg_write_data = r_reg_write_data;

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32x32 general-purpose register file. Two producers compete for the register file's single write port: the ALU write-back path and the load/store unit (LSU) load-return path. The block grants one of them per cycle and drives a registered write port into the register file. It also keeps a per-register pending-write scoreboard so decode can detect RAW hazards on both read addresses.

Parameters:
XLEN, 32, data width of register contents
AW, 5, register address width (2**AW registers; x0 hardwired zero)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
alu_valid  input  1  ALU has a result to write back
alu_ready  output  1  ALU result accepted this cycle (combinational)
alu_dest  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
lsu_valid  input  1  LSU has load data to write back
lsu_ready  output  1  LSU data accepted this cycle (combinational)
lsu_dest  input  AW  LSU destination register
lsu_data  input  XLEN  load data
iss_en  input  1  an instruction that writes iss_dest issues this cycle
iss_dest  input  AW  destination of the issuing instruction
chk_addr_1  input  AW  decode source register 1
chk_addr_2  input  AW  decode source register 2
chk_busy_1  output  1  chk_addr_1 has a write outstanding (combinational)
chk_busy_2  output  1  chk_addr_2 has a write outstanding (combinational)
reg_write_en  output  1  register file write enable (registered)
reg_write_dest  output  AW  register file write address (registered)
reg_write_data  output  XLEN  register file write data (registered)

Behaviour:
- Reset (rst high, asynchronous, clk not required):
  - reg_write_en=0, reg_write_dest=0, reg_write_data=0.
  - pending[31:0]=0.
  - last_grant=ALU.
  - Any accepted-but-unwritten result is discarded.
  - ready outputs follow valid per the rules below, since they are combinational.
- Arbitration (combinational):
  - Only alu_valid high: alu_ready=1.
  - Only lsu_valid high: lsu_ready=1.
  - Both high: grant the requester that is not last_grant. The first conflict after reset therefore goes to the LSU.
  - Neither high: both ready outputs are 0.
  - At most one ready is high in any cycle.
  - A requester that is not granted holds valid, dest and data stable until it is granted. The block does not check this.
- Transfer = valid & ready. On a transfer:
  - last_grant <= granted requester.
  - Next cycle, reg_write_dest/reg_write_data <= granted dest/data, with 1-cycle latency.
  - reg_write_en <= 1 only if dest != 0. A write to x0 is accepted but suppressed, with reg_write_en=0.
  - No transfer: reg_write_en <= 0. dest and data hold their previous values.
- Throughput: one write-back per cycle sustained. A losing requester waits at most 1 cycle while the other requester keeps asserting valid.
- Scoreboard, updated at the clk edge:
  - iss_en & iss_dest != 0 sets pending[iss_dest].
  - A transfer with dest d clears pending[d].
  - Set and clear of the same register in the same cycle: set wins, because a newer producer has issued.
  - pending[0] is always 0.
  - Clearing a register that is not pending is a no-op.
- Busy check (combinational):
  - chk_busy_n = (chk_addr_n != 0) & (pending[chk_addr_n] | (reg_write_en & reg_write_dest == chk_addr_n)).
  - This covers the cycle in which the register file is being written but its read is not yet updated.
- last_grant changes only on a transfer.

Test Plan:
1. Reset with rst pulse while clk is stopped -> reg_write_en=0, all chk_busy=0. Then alu_valid=1, dest=5, data=32'hDEADBEEF -> alu_ready=1 same cycle; next cycle reg_write_en=1, dest=5, data=32'hDEADBEEF.
2. Both valid continuously for 4 cycles (ALU dest=3, LSU dest=4), starting from reset -> grants LSU, ALU, LSU, ALU; write port shows 4, 3, 4, 3 on consecutive cycles; never both ready in one cycle.
3. ALU transfer with dest=0 and data=32'h1234 -> alu_ready=1; next cycle reg_write_en=0.
4. iss_en with iss_dest=7, then chk_addr_1=7 -> chk_busy_1=1. LSU writes dest=7 -> chk_busy_1 stays 1 through the reg_write_en cycle, then 0 the cycle after.
5. Same cycle: iss_en dest=9 and an ALU transfer with dest=9 -> pending[9] remains 1 and chk_busy stays 1 after the write cycle. chk_addr=0 -> chk_busy=0 always.
6. Assert rst mid-transfer, the cycle after a grant -> reg_write_en drops to 0 immediately and pending is cleared. After release, the first conflict is won by the LSU.
